// File: rtl/date_pkg.sv
// ============================================================================
// Module      : date_pkg
// Description : Shared BCD calendar constants and month-length helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package date_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    localparam logic [7:0] D01 = 8'h01;
    localparam logic [7:0] D28 = 8'h28;
    localparam logic [7:0] D29 = 8'h29;
    localparam logic [7:0] D30 = 8'h30;
    localparam logic [7:0] D31 = 8'h31;

    function automatic logic [7:0] last_day(input logic [7:0] month_bcd, input logic leap);
        logic [7:0] result;
        result = D31;
        case (month_bcd)
            FEB:                result = leap ? D29 : D28;
            APR, JUN, SEP, NOV: result = D30;
            default:            result = D31;
        endcase
        return result;
    endfunction

    // Month that precedes month_bcd, with January wrapping to December.
    function automatic logic [7:0] prev_month(input logic [7:0] month_bcd);
        logic [7:0] result;
        result = month_bcd - 8'h01;
        if (month_bcd == JAN)
            result = DEC;
        else if (month_bcd == OCT)
            result = SEP;
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module      : bcd_down_digit
// Description : Single 4-bit BCD down digit with load, wrap value and floor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit
    import date_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic [DIGIT_W-1:0] wrap_val,
    input  logic [DIGIT_W-1:0] min,
    output logic [DIGIT_W-1:0] digit,
    output logic               brw
);

    assign brw = (digit == min);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            digit <= load_val;
        else if (load)
            digit <= load_val;
        else if (en)
            digit <= brw ? wrap_val : digit - DIGIT_W'(1);
    end

endmodule

`default_nettype wire

// File: rtl/date_bcd_down.sv
// ============================================================================
// Module      : date_bcd_down
// Description : BCD month/day calendar down-counter with 01/01 borrow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module date_bcd_down
    import date_pkg::*;
#(
    parameter bit LEAP_DEFAULT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               opr_rst,
    input  logic               stop,
    input  logic               leap,
    input  logic [DIGIT_W-1:0] init_mon_t,
    input  logic [DIGIT_W-1:0] init_mon_u,
    input  logic [DIGIT_W-1:0] init_day_t,
    input  logic [DIGIT_W-1:0] init_day_u,
    output logic [DIGIT_W-1:0] mon_t,
    output logic [DIGIT_W-1:0] mon_u,
    output logic [DIGIT_W-1:0] day_t,
    output logic [DIGIT_W-1:0] day_u,
    output logic               brw
);

    logic               unused_leap_default;
    logic               load;
    logic               day_is_01;
    logic               mon_is_jan;
    logic [7:0]         new_mon;
    logic [7:0]         new_last;
    logic               day_u_brw;
    logic               mon_u_brw;
    logic [DIGIT_W-1:0] day_u_wrap;
    logic [DIGIT_W-1:0] day_u_min;
    logic [DIGIT_W-1:0] mon_u_wrap;
    logic [DIGIT_W-1:0] mon_u_min;

    assign unused_leap_default = LEAP_DEFAULT;

    assign load       = ~opr_rst;
    assign day_is_01  = ({day_t, day_u} == D01);
    assign mon_is_jan = ({mon_t, mon_u} == JAN);
    assign brw        = day_is_01 & mon_is_jan;

    // leap only matters here, i.e. on the edge that leaves day 01 for February.
    assign new_mon  = prev_month({mon_t, mon_u});
    assign new_last = last_day(new_mon, leap);

    // Day units floor at 1 on the month boundary so it reloads the month length.
    assign day_u_wrap = day_is_01 ? new_last[3:0] : DIGIT_W'(9);
    assign day_u_min  = day_is_01 ? DIGIT_W'(1) : DIGIT_W'(0);
    assign mon_u_wrap = mon_is_jan ? DIGIT_W'(2) : DIGIT_W'(9);
    assign mon_u_min  = mon_is_jan ? DIGIT_W'(1) : DIGIT_W'(0);

    bcd_down_digit u_day_u (
        .clk      (clk),
        .rst      (rst),
        .en       (~stop),
        .load     (load),
        .load_val (init_day_u),
        .wrap_val (day_u_wrap),
        .min      (day_u_min),
        .digit    (day_u),
        .brw      (day_u_brw)
    );

    bcd_down_digit u_mon_u (
        .clk      (clk),
        .rst      (rst),
        .en       (~stop & day_is_01),
        .load     (load),
        .load_val (init_mon_u),
        .wrap_val (mon_u_wrap),
        .min      (mon_u_min),
        .digit    (mon_u),
        .brw      (mon_u_brw)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            day_t <= init_day_t;
        end else if (load) begin
            day_t <= init_day_t;
        end else if (!stop) begin
            if (day_is_01)
                day_t <= new_last[7:4];
            else if (day_u_brw)
                day_t <= day_t - DIGIT_W'(1);
        end
    end

    // Month tens only moves when the units digit borrows: 10->09 or 01->12.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mon_t <= init_mon_t;
        end else if (load) begin
            mon_t <= init_mon_t;
        end else if (!stop && day_is_01 && mon_u_brw) begin
            mon_t <= mon_is_jan ? DIGIT_W'(1) : DIGIT_W'(0);
        end
    end

endmodule

`default_nettype wire
